guess_frame_logger: RTL and testbench

//  Responder end of the solver's write_frame/frame_written handshake. Captures each guess
//  and its score (digits, bulls, cows). Holds off the ack until the VGA panel has shown at

---
 rtl/bc_pkg.sv | 24 ++
 rtl/bc_history_ram.sv | 36 +++
 rtl/guess_frame_logger.sv | 145 ++++++++++++++
 tb/tb_guess_frame_logger.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/bc_pkg.sv
// Shared types for the guess frame logger: the logged entry layout and FSM states.
package bc_pkg;

   // One history entry: four guess digits followed by the score.
   typedef struct packed {
      logic [3:0] d0;
      logic [3:0] d1;
      logic [3:0] d2;
      logic [3:0] d3;
      logic [2:0] bulls;
      logic [2:0] cows;
   } guess_entry_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      ACK   = 2'd2,
      REARM = 2'd3
   } log_state_t;

   localparam int         ENTRY_W    = $bits(guess_entry_t);
   localparam logic [2:0] FULL_SCORE = 3'd4;

endpackage

// File: rtl/bc_history_ram.sv
// Circular history storage: one synchronous write port, one registered read port.
// A read of the slot being written in the same cycle returns the previous contents.
module bc_history_ram
   import bc_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wr_en,
   input  logic [AW-1:0] wr_addr,
   input  guess_entry_t wr_data,
   input  logic [AW-1:0] rd_addr,
   output guess_entry_t rd_data
);

   guess_entry_t mem [DEPTH];

   // Write port: contents are never cleared, validity is tracked by the owner.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Read port: registered output, cleared only so the port reads zero after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data <= '0;
      end else begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/guess_frame_logger.sv
// Responder side of the solver write_frame/frame_written handshake. Captures a guess
// and its score, waits for the panel to show complete new frames, logs the entry into
// a circular history and then acknowledges with a one-cycle pulse.
module guess_frame_logger
   import bc_pkg::*;
#(
   parameter int DEPTH            = 16,
   parameter int FRAMES_PER_GUESS = 1,
   parameter bit VSYNC_ACTIVE_LOW = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     write_frame,
   input  logic [3:0]               guessed_number_0,
   input  logic [3:0]               guessed_number_1,
   input  logic [3:0]               guessed_number_2,
   input  logic [3:0]               guessed_number_3,
   input  logic [2:0]               bulls,
   input  logic [2:0]               cows,
   input  logic                     vsync,
   output logic                     frame_written,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [ENTRY_W-1:0]       rd_data,
   output logic [$clog2(DEPTH):0]   entry_count,
   output logic [7:0]               total_guesses,
   output logic                     overflow,
   output logic                     solved
);

   localparam int AW = $clog2(DEPTH);
   localparam int FW = $clog2(FRAMES_PER_GUESS + 1);
   localparam logic [FW-1:0] FRAMES_TARGET = FW'(FRAMES_PER_GUESS);
   localparam logic [AW:0]   DEPTH_COUNT   = (AW + 1)'(DEPTH);
   localparam logic [AW-1:0] LAST_SLOT     = AW'(DEPTH - 1);

   log_state_t   state;
   guess_entry_t capture;
   logic         vs_prev;
   logic         seen_start;
   logic [FW-1:0] fcnt;
   logic [AW-1:0] wr_ptr;
   logic         vs_act;
   logic         vs_start;
   logic         vs_end;
   logic         mem_we;
   guess_entry_t ram_rd;

   assign vs_act   = vsync ^ VSYNC_ACTIVE_LOW;
   assign vs_start = vs_act & ~vs_prev;
   assign vs_end   = ~vs_act & vs_prev;
   // The entry is committed in the last WAIT cycle; a reset in that cycle aborts it.
   assign mem_we   = ~rst && (state == WAIT) && (fcnt == FRAMES_TARGET);
   assign rd_data  = ram_rd;

   bc_history_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_history (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (mem_we),
      .wr_addr (wr_ptr),
      .wr_data (capture),
      .rd_addr (rd_addr),
      .rd_data (ram_rd)
   );

   // Remember the previous normalised vsync level for edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         vs_prev <= 1'b0;
      end else begin
         vs_prev <= vs_act;
      end
   end

   // Handshake FSM with frame counting, history pointer, counters and sticky flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         capture       <= '0;
         seen_start    <= 1'b0;
         fcnt          <= '0;
         wr_ptr        <= '0;
         frame_written <= 1'b0;
         entry_count   <= '0;
         total_guesses <= '0;
         overflow      <= 1'b0;
         solved        <= 1'b0;
      end else begin
         frame_written <= 1'b0;
         case (state)
            IDLE: begin
               if (write_frame) begin
                  capture.d0    <= guessed_number_0;
                  capture.d1    <= guessed_number_1;
                  capture.d2    <= guessed_number_2;
                  capture.d3    <= guessed_number_3;
                  capture.bulls <= bulls;
                  capture.cows  <= cows;
                  // Edges seen in the capture cycle are deliberately dropped, so a pulse
                  // already in progress can never complete a frame.
                  seen_start    <= 1'b0;
                  fcnt          <= '0;
                  state         <= WAIT;
               end
            end
            WAIT: begin
               if (fcnt == FRAMES_TARGET) begin
                  frame_written <= 1'b1;
                  state         <= ACK;
               end else if (vs_end && seen_start) begin
                  fcnt       <= fcnt + 1'b1;
                  seen_start <= 1'b0;
               end else if (vs_start) begin
                  seen_start <= 1'b1;
               end
            end
            ACK: begin
               if (entry_count == DEPTH_COUNT) begin
                  overflow <= 1'b1;
               end else begin
                  entry_count <= entry_count + 1'b1;
               end
               if (total_guesses != 8'hFF) begin
                  total_guesses <= total_guesses + 1'b1;
               end
               if (capture.bulls == FULL_SCORE) begin
                  solved <= 1'b1;
               end
               wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + 1'b1;
               state  <= REARM;
            end
            REARM: begin
               // Wait for the solver to drop its request so one request yields one ack.
               if (!write_frame) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_guess_frame_logger.sv
// Randomised bench for guess_frame_logger: two instances (default, and a 4-deep
// three-frame variant) checked against a history-list model of logged guesses.
module tb_guess_frame_logger;

   logic        clk = 1'b0;
   logic        rst;
   logic        wf;
   logic        vs_act;
   logic        vsync;
   logic [3:0]  g0, g1, g2, g3;
   logic [2:0]  bulls, cows;
   logic [3:0]  rd_addr;
   bit          sel;

   logic        wf0, wf3;
   logic        fw0, fw3;
   logic [21:0] rd0, rd3;
   logic [4:0]  ec0;
   logic [2:0]  ec3;
   logic [7:0]  tg0, tg3;
   logic        ov0, ov3, sv0, sv3;

   logic        fw_s, ov_s, sv_s;
   logic [21:0] rd_s;
   logic [31:0] ec_s, tg_s;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          log_n [2];
   bit          solved_m [2];
   logic [21:0] mem_m [2][16];
   int          dep [2] = '{16, 4};
   int          fpg [2] = '{1, 3};

   always #5 clk = ~clk;

   assign vsync = ~vs_act;
   assign wf0   = wf & ~sel;
   assign wf3   = wf & sel;
   assign fw_s  = sel ? fw3 : fw0;
   assign rd_s  = sel ? rd3 : rd0;
   assign ec_s  = sel ? 32'(ec3) : 32'(ec0);
   assign tg_s  = sel ? 32'(tg3) : 32'(tg0);
   assign ov_s  = sel ? ov3 : ov0;
   assign sv_s  = sel ? sv3 : sv0;

   guess_frame_logger #(.DEPTH(16), .FRAMES_PER_GUESS(1), .VSYNC_ACTIVE_LOW(1'b1)) dut (
      .clk(clk), .rst(rst), .write_frame(wf0),
      .guessed_number_0(g0), .guessed_number_1(g1), .guessed_number_2(g2), .guessed_number_3(g3),
      .bulls(bulls), .cows(cows), .vsync(vsync), .frame_written(fw0),
      .rd_addr(rd_addr), .rd_data(rd0), .entry_count(ec0), .total_guesses(tg0),
      .overflow(ov0), .solved(sv0));

   guess_frame_logger #(.DEPTH(4), .FRAMES_PER_GUESS(3), .VSYNC_ACTIVE_LOW(1'b1)) dut3 (
      .clk(clk), .rst(rst), .write_frame(wf3),
      .guessed_number_0(g0), .guessed_number_1(g1), .guessed_number_2(g2), .guessed_number_3(g3),
      .bulls(bulls), .cows(cows), .vsync(vsync), .frame_written(fw3),
      .rd_addr(rd_addr[1:0]), .rd_data(rd3), .entry_count(ec3), .total_guesses(tg3),
      .overflow(ov3), .solved(sv3));

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance to the next falling edge and check the ack level there.
   task automatic tick(input logic exp_fw);
      @(negedge clk);
      check_val("ack", {31'b0, fw_s}, {31'b0, exp_fw});
   endtask

   function automatic logic [21:0] entry_of(input int a, b, c, d, bu, co);
      return 22'(a * 262144 + b * 16384 + c * 1024 + d * 64 + bu * 8 + co);
   endfunction

   // One full request: optional pulse already active at capture, then the required
   // number of complete pulses, ack check, counter check, hold, release and readback.
   task automatic run_guess(input int w, input int a, b, c, d, bu, co, input bit mid, input int hold);
      int slot;
      int n;
      int lim;
      int r;
      if (mid) begin
         vs_act = 1'b1;
         tick(1'b0);
         tick(1'b0);
      end
      g0 = 4'(a); g1 = 4'(b); g2 = 4'(c); g3 = 4'(d);
      bulls = 3'(bu); cows = 3'(co);
      wf = 1'b1;
      if (mid) begin
         repeat ($urandom_range(1, 3)) tick(1'b0);
         vs_act = 1'b0;
      end
      for (int p = 1; p <= fpg[w]; p++) begin
         repeat ($urandom_range(1, 4)) begin
            tick(1'b0);
            g0 = 4'($urandom); g1 = 4'($urandom); g2 = 4'($urandom); g3 = 4'($urandom);
            bulls = 3'($urandom_range(0, 4)); cows = 3'($urandom_range(0, 4));
         end
         vs_act = 1'b1;
         repeat ($urandom_range(1, 3)) tick(1'b0);
         vs_act = 1'b0;
      end
      tick(1'b0);
      tick(1'b1);
      n = log_n[w];
      slot = n % dep[w];
      mem_m[w][slot] = entry_of(a, b, c, d, bu, co);
      log_n[w] = n + 1;
      if (bu == 4) solved_m[w] = 1'b1;
      tick(1'b0);
      n = log_n[w];
      check_val("entry_count", ec_s, 32'((n > dep[w]) ? dep[w] : n));
      check_val("total_guesses", tg_s, 32'((n > 255) ? 255 : n));
      check_val("overflow", {31'b0, ov_s}, {31'b0, n > dep[w]});
      check_val("solved", {31'b0, sv_s}, {31'b0, solved_m[w]});
      repeat (hold) tick(1'b0);
      wf = 1'b0;
      tick(1'b0);
      rd_addr = 4'(slot);
      tick(1'b0);
      check_val("rd_new", {10'b0, rd_s}, {10'b0, mem_m[w][slot]});
      lim = (n > dep[w]) ? dep[w] : n;
      r = $urandom_range(0, lim - 1);
      rd_addr = 4'(r);
      tick(1'b0);
      check_val("rd_any", {10'b0, rd_s}, {10'b0, mem_m[w][r]});
      $display("guess dut%0d #%0d slot %0d entry %06h mid=%0d hold=%0d", w, n, slot,
               mem_m[w][slot], mid, hold);
   endtask

   initial begin
      sel = 1'b0; rst = 1'b1; wf = 1'b0; vs_act = 1'b0;
      g0 = '0; g1 = '0; g2 = '0; g3 = '0; bulls = '0; cows = '0; rd_addr = '0;
      log_n = '{0, 0};
      solved_m = '{1'b0, 1'b0};
      repeat (3) tick(1'b0);
      rst = 1'b0;
      check_val("rst_ec0", 32'(ec0), 0);
      check_val("rst_tg0", 32'(tg0), 0);
      check_val("rst_ov0", {31'b0, ov0}, 0);
      check_val("rst_sv0", {31'b0, sv0}, 0);
      check_val("rst_fw3", {31'b0, fw3}, 0);
      check_val("rst_ec3", 32'(ec3), 0);
      $display("reset checked");

      // Directed guess 5,7,4,8 with a full score.
      run_guess(0, 5, 7, 4, 8, 4, 0, 1'b0, 2);
      rd_addr = 4'd0;
      tick(1'b0);
      check_val("first_entry", {10'b0, rd_s}, 32'h0015_D220);

      // Request raised while a pulse is already active.
      run_guess(0, 1, 2, 3, 4, 1, 2, 1'b1, 0);
      // Long hold after the ack must not produce a second ack.
      run_guess(0, 9, 8, 7, 6, 0, 3, 1'b0, 10);

      // Random guesses, enough to wrap the 16-deep history (17 logged in total).
      for (int i = 0; i < 14; i++) begin
         run_guess(0, $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9),
                   $urandom_range(0, 9), $urandom_range(0, 3), $urandom_range(0, 4),
                   1'($urandom_range(0, 1)), $urandom_range(0, 10));
      end

      // Three frames per guess, 4-deep history.
      sel = 1'b1;
      for (int i = 0; i < 6; i++) begin
         run_guess(1, $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9),
                   $urandom_range(0, 9), $urandom_range(0, 4), $urandom_range(0, 4),
                   1'($urandom_range(0, 1)), $urandom_range(0, 3));
      end

      // Reset in the cycle before the ack would issue.
      sel = 1'b0;
      g0 = 4'd3; g1 = 4'd3; g2 = 4'd3; g3 = 4'd3; bulls = 3'd2; cows = 3'd1;
      wf = 1'b1;
      tick(1'b0);
      vs_act = 1'b1;
      tick(1'b0);
      vs_act = 1'b0;
      tick(1'b0);
      rst = 1'b1;
      wf = 1'b0;
      tick(1'b0);
      rst = 1'b0;
      repeat (5) tick(1'b0);
      log_n = '{0, 0};
      solved_m = '{1'b0, 1'b0};
      check_val("abort_ec0", 32'(ec0), 0);
      check_val("abort_tg0", 32'(tg0), 0);
      check_val("abort_ov0", {31'b0, ov0}, 0);
      check_val("abort_sv0", {31'b0, sv0}, 0);
      check_val("abort_ec3", 32'(ec3), 0);
      check_val("abort_ov3", {31'b0, ov3}, 0);
      $display("reset during wait checked");

      // Logging restarts at slot 0 after the reset.
      run_guess(0, 2, 4, 6, 8, 2, 2, 1'b0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
